// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, 5-8 data bits, optional parity, 1/2 stop bits.
// Byte is presented one cycle after the last stop sample; if the previous byte is still unaccepted, the new one is dropped and overrun pulses.
module uart_rx_core #(
   parameter int DIV_W = 32
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic [DIV_W-1:0] cfg_clk_div_i,
   input  logic             cfg_parity_en_i,
   input  logic             cfg_parity_type_i,
   input  logic             cfg_extra_stop_i,
   input  logic [3:0]       cfg_data_bits_i,
   input  logic             rx_i,
   output logic [7:0]       data_o,
   output logic             data_valid_o,
   input  logic             data_ready_i,
   output logic             parity_err_o,
   output logic             frame_err_o,
   output logic             overrun_o,
   output logic             busy_o
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2
   } state_t;

   state_t state, state_nxt;

   logic             rx_m, rx_s, rx_d;
   logic             fall;
   logic             start;
   logic             sample;
   logic             done;
   logic             last_data;

   logic [DIV_W-1:0] div_eff;
   logic [3:0]       nbits_eff;

   logic [DIV_W-1:0] div_q;
   logic [3:0]       nbits_q;
   logic             par_en_q;
   logic             par_odd_q;
   logic             two_stop_q;

   logic [DIV_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             perr_acc;
   logic             ferr_acc;
   logic             ferr_fin;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx_i;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign fall = rx_d & ~rx_s;

   assign div_eff   = (cfg_clk_div_i < DIV_W'(4)) ? DIV_W'(4) : cfg_clk_div_i;
   assign nbits_eff = (cfg_data_bits_i > 4'd8) ? 4'd8 :
                      (cfg_data_bits_i < 4'd5) ? 4'd5 : cfg_data_bits_i;

   assign start     = (state == IDLE) && fall;
   assign sample    = (state != IDLE) && (cnt == '0);
   assign last_data = ({1'b0, bit_idx} == (nbits_q - 4'd1));
   assign ferr_fin  = ferr_acc | ~rx_s;
   assign busy_o    = (state != IDLE);

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (fall) state_nxt = START;
         end
         START: begin
            // a line that is high again at mid-start-bit was only a glitch
            if (sample) state_nxt = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (sample && last_data) state_nxt = par_en_q ? PARITY : STOP1;
         end
         PARITY: begin
            if (sample) state_nxt = STOP1;
         end
         STOP1: begin
            if (sample) begin
               state_nxt = two_stop_q ? STOP2 : IDLE;
               done      = ~two_stop_q;
            end
         end
         STOP2: begin
            if (sample) begin
               state_nxt = IDLE;
               done      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         perr_acc   <= 1'b0;
         ferr_acc   <= 1'b0;
         div_q      <= '0;
         nbits_q    <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         two_stop_q <= 1'b0;
      end else begin
         if (start) begin
            // half a bit first so every later sample sits at mid-bit
            cnt        <= (div_eff >> 1) - DIV_W'(1);
            bit_idx    <= '0;
            shreg      <= '0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
            div_q      <= div_eff;
            nbits_q    <= nbits_eff;
            par_en_q   <= cfg_parity_en_i;
            par_odd_q  <= cfg_parity_type_i;
            two_stop_q <= cfg_extra_stop_i;
         end else if (state != IDLE) begin
            if (cnt == '0) cnt <= div_q - DIV_W'(1);
            else           cnt <= cnt - DIV_W'(1);
         end

         if (sample) begin
            case (state)
               DATA: begin
                  shreg[bit_idx] <= rx_s;
                  bit_idx        <= bit_idx + 3'd1;
               end
               // unused upper bits of shreg are zero, so they do not disturb the XOR
               PARITY: perr_acc <= (rx_s != ((^shreg) ^ par_odd_q));
               STOP1, STOP2: begin
                  if (!rx_s) ferr_acc <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         data_o       <= '0;
         data_valid_o <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         overrun_o <= 1'b0;
         if (data_valid_o && data_ready_i) data_valid_o <= 1'b0;
         if (done) begin
            if (!data_valid_o || data_ready_i) begin
               data_o       <= shreg;
               parity_err_o <= perr_acc;
               frame_err_o  <= ferr_fin;
               data_valid_o <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed vector table, corner-case sequences and randomized frames vs a frame-level model.
module tb_uart_rx_core;

   logic        clk = 1'b0;
   logic        srst;
   logic [31:0] cfg_div;
   logic        cfg_pen, cfg_podd, cfg_two;
   logic [3:0]  cfg_nb;
   logic        rx;
   logic [7:0]  data;
   logic        valid, ready, perr, ferr, ovr, busy;

   always #5 clk = ~clk;

   uart_rx_core #(.DIV_W(32)) dut (
      .clk_i            (clk),
      .srst_i           (srst),
      .cfg_clk_div_i    (cfg_div),
      .cfg_parity_en_i  (cfg_pen),
      .cfg_parity_type_i(cfg_podd),
      .cfg_extra_stop_i (cfg_two),
      .cfg_data_bits_i  (cfg_nb),
      .rx_i             (rx),
      .data_o           (data),
      .data_valid_o     (valid),
      .data_ready_i     (ready),
      .parity_err_o     (perr),
      .frame_err_o      (ferr),
      .overrun_o        (ovr),
      .busy_o           (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_start  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } res_t;

   res_t res_q[$];
   int   rise_q[$];
   int   ovr_cnt = 0;
   logic prev_valid = 1'b0;

   initial begin
      res_t r;
      forever begin
         @(negedge clk);
         #1;
         if (!srst) begin
            if (valid && ready) begin
               r.d = data; r.pe = perr; r.fe = ferr;
               res_q.push_back(r);
            end
            if (valid && !prev_valid) rise_q.push_back(cyc);
            if (ovr) ovr_cnt++;
         end
         prev_valid = valid;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int eff_div(input int v);
      return (v < 4) ? 4 : v;
   endfunction

   function automatic int eff_nb(input int v);
      return (v < 5) ? 5 : ((v > 8) ? 8 : v);
   endfunction

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input int dv, input int nb, input bit pen, input bit pbit,
                             input bit two, input logic [7:0] d, input bit stop_low,
                             input bit scramble);
      rx = 1'b0;
      t_start = cyc;
      if (scramble) begin
         repeat (4) @(negedge clk);
         cfg_div  = $urandom_range(0, 40);
         cfg_nb   = 4'($urandom_range(0, 15));
         cfg_pen  = 1'($urandom_range(0, 1));
         cfg_podd = 1'($urandom_range(0, 1));
         cfg_two  = 1'($urandom_range(0, 1));
         repeat (dv - 4) @(negedge clk);
      end else begin
         repeat (dv) @(negedge clk);
      end
      for (int i = 0; i < nb; i++) hold(d[i], dv);
      if (pen) hold(pbit, dv);
      hold(stop_low ? 1'b0 : 1'b1, dv);
      if (two) hold(stop_low ? 1'b0 : 1'b1, dv);
      rx = 1'b1;
   endtask

   task automatic run_frame(input string name, input int dr, input int nr, input bit pen,
                            input bit podd, input bit two, input logic [7:0] d, input bit pbit,
                            input bit sl, input logic [7:0] ed, input bit epe, input bit efe,
                            input bit scr);
      int   dv, nb, exp_rise;
      res_t r;
      cfg_div = dr; cfg_nb = 4'(nr); cfg_pen = pen; cfg_podd = podd; cfg_two = two;
      dv = eff_div(dr);
      nb = eff_nb(nr);
      res_q.delete();
      rise_q.delete();
      send_frame(dv, nb, pen, pbit, two, d, sl, scr);
      exp_rise = t_start + 3 + dv / 2 + (nb + int'(pen) + (two ? 2 : 1)) * dv;
      repeat (4) @(negedge clk);
      check({name, ".count"}, res_q.size(), 1);
      if (res_q.size() > 0) begin
         r = res_q.pop_front();
         check({name, ".data"}, r.d, ed);
         check({name, ".perr"}, r.pe, epe);
         check({name, ".ferr"}, r.fe, efe);
      end
      if (rise_q.size() > 0) check({name, ".latency"}, rise_q.pop_front(), exp_rise);
   endtask

   typedef struct {
      int         dr;
      int         nr;
      bit         pen;
      bit         podd;
      bit         two;
      logic [7:0] d;
      bit         pbit;
      bit         sl;
      logic [7:0] ed;
      bit         epe;
      bit         efe;
   } vec_t;

   vec_t tbl[9];

   initial begin
      tbl[0] = '{8,  8, 0, 0, 0, 8'hA5, 0, 0, 8'hA5, 0, 0};
      tbl[1] = '{16, 7, 1, 1, 1, 8'h55, 1, 0, 8'h55, 0, 0};
      tbl[2] = '{16, 7, 1, 1, 1, 8'h55, 0, 0, 8'h55, 1, 0};
      tbl[3] = '{8,  8, 0, 0, 0, 8'h3C, 0, 1, 8'h3C, 0, 1};
      tbl[4] = '{6,  5, 1, 0, 0, 8'h15, 1, 0, 8'h15, 0, 0};
      tbl[5] = '{2, 12, 0, 0, 0, 8'hC3, 0, 0, 8'hC3, 0, 0};
      tbl[6] = '{9,  3, 0, 0, 1, 8'hFF, 0, 0, 8'h1F, 0, 0};
      tbl[7] = '{10, 6, 1, 0, 1, 8'h2A, 0, 0, 8'h2A, 1, 0};
      tbl[8] = '{8,  8, 1, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0};

      srst = 1'b1; rx = 1'b1; ready = 1'b1;
      cfg_div = 8; cfg_nb = 4'd8; cfg_pen = 0; cfg_podd = 0; cfg_two = 0;
      repeat (3) @(negedge clk);
      srst = 1'b0;
      check("rst.data", data, 0);
      check("rst.valid", valid, 0);
      check("rst.perr", perr, 0);
      check("rst.ferr", ferr, 0);
      check("rst.ovr", ovr, 0);
      check("rst.busy", busy, 0);
      repeat (4) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run_frame($sformatf("vec%0d", i), tbl[i].dr, tbl[i].nr, tbl[i].pen, tbl[i].podd,
                   tbl[i].two, tbl[i].d, tbl[i].pbit, tbl[i].sl, tbl[i].ed, tbl[i].epe,
                   tbl[i].efe, 1'b0);
      end

      // break: line low for 12 bit times yields one 0x00 frame with framing error
      cfg_div = 8; cfg_nb = 4'd8; cfg_pen = 0; cfg_two = 0;
      res_q.delete(); rise_q.delete();
      hold(1'b0, 96);
      hold(1'b1, 40);
      check("break.count", res_q.size(), 1);
      if (res_q.size() > 0) begin
         check("break.data", res_q[0].d, 8'h00);
         check("break.ferr", res_q[0].fe, 1);
         check("break.perr", res_q[0].pe, 0);
      end

      // glitch: two low cycles with div 16 must be discarded as a false start
      cfg_div = 16;
      res_q.delete(); rise_q.delete();
      hold(1'b0, 2);
      hold(1'b1, 2);
      check("glitch.busy_start", busy, 1);
      hold(1'b1, 8);
      check("glitch.busy_end", busy, 0);
      check("glitch.no_valid", rise_q.size(), 0);
      repeat (4) @(negedge clk);
      run_frame("glitch.next", 16, 8, 0, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0, 1'b0);

      // overrun: two back-to-back frames with consumer stalled
      ready = 1'b0;
      cfg_div = 8; cfg_nb = 4'd8; cfg_pen = 0; cfg_two = 0;
      res_q.delete(); rise_q.delete(); ovr_cnt = 0;
      send_frame(8, 8, 0, 0, 0, 8'h11, 0, 0);
      send_frame(8, 8, 0, 0, 0, 8'h22, 0, 0);
      repeat (4) @(negedge clk);
      check("ovr.valid", valid, 1);
      check("ovr.data", data, 8'h11);
      check("ovr.pulses", ovr_cnt, 1);
      check("ovr.rises", rise_q.size(), 1);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      @(negedge clk);
      check("ovr.valid_clr", valid, 0);
      check("ovr.accepted", res_q.size(), 1);
      if (res_q.size() > 0) check("ovr.acc_data", res_q[0].d, 8'h11);

      // reset in the middle of DATA while an older byte is still pending
      send_frame(8, 8, 0, 0, 0, 8'h5A, 0, 0);
      repeat (4) @(negedge clk);
      check("rstmid.pending", valid, 1);
      hold(1'b0, 8);
      hold(1'b0, 24);
      check("rstmid.busy_pre", busy, 1);
      rx = 1'b1;
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      check("rstmid.data", data, 0);
      check("rstmid.valid", valid, 0);
      check("rstmid.perr", perr, 0);
      check("rstmid.ferr", ferr, 0);
      check("rstmid.ovr", ovr, 0);
      check("rstmid.busy", busy, 0);
      res_q.delete(); rise_q.delete();
      repeat (100) @(negedge clk);
      check("rstmid.quiet", rise_q.size(), 0);
      ready = 1'b1;
      run_frame("rstmid.next", 8, 8, 0, 0, 0, 8'h0F, 0, 0, 8'h0F, 0, 0, 1'b0);

      // randomized frames against a frame-level model, cfg scrambled mid-frame
      for (int i = 0; i < 40; i++) begin
         int         dr, nr, nb;
         bit         pen, podd, two, flip, sl, pbit;
         logic [7:0] d, ed;
         dr   = $urandom_range(0, 20);
         nr   = $urandom_range(0, 15);
         pen  = 1'($urandom_range(0, 1));
         podd = 1'($urandom_range(0, 1));
         two  = 1'($urandom_range(0, 1));
         flip = ($urandom_range(0, 3) == 0);
         sl   = ($urandom_range(0, 3) == 0);
         d    = 8'($urandom);
         nb   = eff_nb(nr);
         ed   = d & 8'((1 << nb) - 1);
         // correct parity bit makes the total count of ones even or odd as configured
         pbit = ((($countones(ed) % 2) == 1) != podd) ^ flip;
         run_frame($sformatf("rnd%0d", i), dr, nr, pen, podd, two, d, pbit, sl, ed,
                   pen & flip, sl, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
